pulse_sync_multi: RTL and testbench

PULSE_SYNC_MULTI -- requirements
Module: pulse_sync_multi

---
 rtl/pulse_sync_multi.sv | 101 ++++++++++
 tb/tb_pulse_sync_multi.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sync_multi.sv
`default_nettype none
// ============================================================================
// Module      : pulse_sync_multi
// Description : N independent channels. Each channel synchronises an
//               asynchronous level and debounces it. It emits a one-cycle
//               strobe on every accepted, mode-enabled edge and keeps sticky
//               pending/overflow flags that ack clears.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_sync_multi #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   async_in,
    input  logic [2*N-1:0] mode,
    input  logic [N-1:0]   ack,
    output logic [N-1:0]   level_out,
    output logic [N-1:0]   pulse_out,
    output logic [N-1:0]   event_pending,
    output logic [N-1:0]   overflow
);

    localparam int            C_CW      = $clog2(DEBOUNCE + 1);
    localparam logic [C_CW-1:0] C_CNT_MAX = C_CW'(DEBOUNCE - 1);

    generate
        for (genvar i = 0; i < N; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic                   r_filt;
            logic [C_CW-1:0]        r_cnt;
            logic                   r_pulse;
            logic                   r_pend;
            logic                   r_ovf;
            logic                   w_s;
            logic                   w_accept;
            logic                   w_event;

            assign w_s      = r_sync[SYNC_STAGES-1];
            // A level change is accepted when it has been held for DEBOUNCE cycles
            assign w_accept = (w_s != r_filt) && (r_cnt == C_CNT_MAX);
            // The new level tells the direction: bit 0 enables rising, bit 1 falling
            assign w_event  = w_accept && (w_s ? mode[2*i] : mode[2*i+1]);

            // Synchroniser chain; the input enters at bit 0
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], async_in[i]};
                end
            end

            // Debounce: count consecutive mismatch cycles and flip the filtered level on the last one
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_filt <= 1'b0;
                    r_cnt  <= '0;
                end else if (w_s == r_filt) begin
                    r_cnt  <= '0;
                end else if (w_accept) begin
                    r_filt <= w_s;
                    r_cnt  <= '0;
                end else begin
                    r_cnt  <= r_cnt + 1'b1;
                end
            end

            // Strobe and sticky flags; an event arriving with its ack counts as fresh and is not an overflow
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pulse <= 1'b0;
                    r_pend  <= 1'b0;
                    r_ovf   <= 1'b0;
                end else begin
                    r_pulse <= w_event;
                    if (w_event) begin
                        r_pend <= 1'b1;
                        if (ack[i]) begin
                            r_ovf <= 1'b0;
                        end else if (r_pend) begin
                            r_ovf <= 1'b1;
                        end
                    end else if (ack[i]) begin
                        r_pend <= 1'b0;
                        r_ovf  <= 1'b0;
                    end
                end
            end

            assign level_out[i]     = r_filt;
            assign pulse_out[i]     = r_pulse;
            assign event_pending[i] = r_pend;
            assign overflow[i]      = r_ovf;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pulse_sync_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_sync_multi
// Description : Directed self-checking bench for pulse_sync_multi at its
//               default parameters (N=4, SYNC_STAGES=2, DEBOUNCE=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_sync_multi;

    logic       clk;
    logic       rst;
    logic [3:0] async_in;
    logic [7:0] mode;
    logic [3:0] ack;
    logic [3:0] level_out;
    logic [3:0] pulse_out;
    logic [3:0] event_pending;
    logic [3:0] overflow;

    int n_tests;
    int n_fail;

    pulse_sync_multi #(.N(4), .SYNC_STAGES(2), .DEBOUNCE(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .async_in     (async_in),
        .mode         (mode),
        .ack          (ack),
        .level_out    (level_out),
        .pulse_out    (pulse_out),
        .event_pending(event_pending),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled and inputs changed 1 ns later
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; async_in = 4'h0; mode = 8'h00; ack = 4'h0;
        tick(3);
        n_tests++;
        if ({level_out, pulse_out, event_pending, overflow} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0000", {level_out, pulse_out, event_pending, overflow});
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_rise();
        mode = 8'b0000_0001;
        async_in[0] = 1'b1;
        tick(5);
        n_tests++;
        if (level_out[0] !== 1'b0 || pulse_out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_early_e5: level %b pulse %b want 0 0", level_out[0], pulse_out[0]);
        end
        tick(1);
        n_tests++;
        if (level_out !== 4'b0001 || pulse_out !== 4'b0001 || event_pending !== 4'b0001) begin
            n_fail++;
            $display("FAIL rise_e6: level %b pulse %b pend %b want 0001 0001 0001", level_out, pulse_out, event_pending);
        end
        tick(1);
        n_tests++;
        if (pulse_out[0] !== 1'b0 || event_pending[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rise_e7: pulse %b pend %b want 0 1", pulse_out[0], event_pending[0]);
        end
        ack[0] = 1'b1; tick(1); ack[0] = 1'b0;
        n_tests++;
        if (event_pending[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_ack: pend %b want 0", event_pending[0]);
        end
        // falling edge with rising-only mode: level follows, no strobe
        async_in[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            n_tests++;
            if (pulse_out[0] !== 1'b0 || event_pending[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL fall_masked: pulse %b pend %b want 0 0", pulse_out[0], event_pending[0]);
            end
        end
        n_tests++;
        if (level_out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_masked_level: got %b want 0", level_out[0]);
        end
    endtask

    task automatic test_glitch();
        mode = 8'b0000_0100;
        async_in[1] = 1'b1;
        tick(3);
        async_in[1] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            n_tests++;
            if (level_out[1] !== 1'b0 || pulse_out[1] !== 1'b0 || event_pending[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch: level %b pulse %b pend %b want 0 0 0", level_out[1], pulse_out[1], event_pending[1]);
            end
        end
    endtask

    task automatic test_disabled();
        mode = 8'b0000_0000;
        async_in[1] = 1'b1;
        tick(6);
        n_tests++;
        if (level_out[1] !== 1'b1 || pulse_out[1] !== 1'b0 || event_pending[1] !== 1'b0 || overflow[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL disabled_rise: level %b pulse %b pend %b ovf %b want 1 0 0 0", level_out[1], pulse_out[1], event_pending[1], overflow[1]);
        end
        async_in[1] = 1'b0;
        tick(6);
        n_tests++;
        if (level_out[1] !== 1'b0 || event_pending[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL disabled_fall: level %b pend %b want 0 0", level_out[1], event_pending[1]);
        end
    endtask

    task automatic test_both_edges();
        mode = 8'b0011_0000;
        async_in[2] = 1'b1;
        tick(6);
        n_tests++;
        if (pulse_out[2] !== 1'b1 || event_pending[2] !== 1'b1 || overflow[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL both_rise: pulse %b pend %b ovf %b want 1 1 0", pulse_out[2], event_pending[2], overflow[2]);
        end
        tick(1);
        n_tests++;
        if (pulse_out[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL both_rise_width: pulse %b want 0", pulse_out[2]);
        end
        tick(13);
        async_in[2] = 1'b0;
        tick(5);
        n_tests++;
        if (pulse_out[2] !== 1'b0 || level_out[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL both_fall_early: pulse %b level %b want 0 1", pulse_out[2], level_out[2]);
        end
        tick(1);
        n_tests++;
        if (pulse_out[2] !== 1'b1 || level_out[2] !== 1'b0 || event_pending[2] !== 1'b1 || overflow[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL both_fall: pulse %b level %b pend %b ovf %b want 1 0 1 1", pulse_out[2], level_out[2], event_pending[2], overflow[2]);
        end
        tick(1);
        n_tests++;
        if (pulse_out[2] !== 1'b0 || overflow[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL both_fall_width: pulse %b ovf %b want 0 1", pulse_out[2], overflow[2]);
        end
        ack[2] = 1'b1; tick(1); ack[2] = 1'b0;
        n_tests++;
        if (event_pending[2] !== 1'b0 || overflow[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL both_ack: pend %b ovf %b want 0 0", event_pending[2], overflow[2]);
        end
    endtask

    task automatic test_ack_coincide();
        mode = 8'b0100_0000;
        async_in[3] = 1'b1;
        tick(6);
        n_tests++;
        if (event_pending[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL coinc_first: pend %b want 1", event_pending[3]);
        end
        async_in[3] = 1'b0;
        tick(8);
        async_in[3] = 1'b1;
        tick(5);
        ack[3] = 1'b1;
        tick(1);
        ack[3] = 1'b0;
        n_tests++;
        if (pulse_out[3] !== 1'b1 || event_pending[3] !== 1'b1 || overflow[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL coinc_ack: pulse %b pend %b ovf %b want 1 1 0", pulse_out[3], event_pending[3], overflow[3]);
        end
        ack[3] = 1'b1; tick(1); ack[3] = 1'b0;
        n_tests++;
        if (event_pending[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL coinc_clear: pend %b want 0", event_pending[3]);
        end
    endtask

    task automatic test_reset_mid();
        mode = 8'b0000_0001;
        async_in = 4'b0001;
        tick(4);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick(1);
            n_tests++;
            if ({level_out, pulse_out, event_pending, overflow} !== 16'h0000) begin
                n_fail++;
                $display("FAIL rst_mid_hold: got %h want 0000", {level_out, pulse_out, event_pending, overflow});
            end
        end
        rst = 1'b0;
        tick(5);
        n_tests++;
        if (pulse_out !== 4'b0000 || level_out !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_e5: pulse %b level %b want 0000 0000", pulse_out, level_out);
        end
        tick(1);
        n_tests++;
        if (pulse_out !== 4'b0001 || level_out !== 4'b0001 || event_pending !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid_e6: pulse %b level %b pend %b want 0001 0001 0001", pulse_out, level_out, event_pending);
        end
    endtask

    task automatic test_all_channels();
        async_in = 4'b0000;
        mode = 8'b0101_0101;
        tick(8);
        ack = 4'b1111; tick(1); ack = 4'b0000;
        async_in = 4'b1111;
        tick(5);
        n_tests++;
        if (pulse_out !== 4'b0000) begin
            n_fail++;
            $display("FAIL all_e5: pulse %b want 0000", pulse_out);
        end
        tick(1);
        n_tests++;
        if (pulse_out !== 4'b1111 || event_pending !== 4'b1111 || overflow !== 4'b0000) begin
            n_fail++;
            $display("FAIL all_e6: pulse %b pend %b ovf %b want 1111 1111 0000", pulse_out, event_pending, overflow);
        end
        tick(1);
        n_tests++;
        if (pulse_out !== 4'b0000 || level_out !== 4'b1111) begin
            n_fail++;
            $display("FAIL all_e7: pulse %b level %b want 0000 1111", pulse_out, level_out);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; async_in = 4'h0; mode = 8'h00; ack = 4'h0;
        #1;
        test_reset();
        test_rise();
        test_glitch();
        test_disabled();
        test_both_edges();
        test_ack_coincide();
        test_reset_mid();
        test_all_channels();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
